// File: rtl/ushift_pkg.sv
// ushift_pkg: opcodes, FSM states and step-count rule shared by the
// universal shift register and its step function.
package ushift_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SR   = 3'b001;
    localparam logic [2:0] OP_SL   = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_INV  = 3'b100;
    localparam logic [2:0] OP_RR   = 3'b101;
    localparam logic [2:0] OP_RL   = 3'b110;
    localparam logic [2:0] OP_SWAP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Shifts and rotates honour amt; the remaining ops run at most once.
    function automatic logic repeats(input logic [2:0] op);
        return (op == OP_SR) || (op == OP_SL) || (op == OP_RR) || (op == OP_RL);
    endfunction

endpackage

// File: rtl/ushift_step.sv
// ushift_step: one combinational step of the universal shift register.
module ushift_step
    import ushift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] ld,
    input  logic             sin_lo,
    input  logic             sin_hi,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (op)
            OP_SR:   nxt = {cur[WIDTH-2:0], sin_lo};
            OP_SL:   nxt = {sin_hi, cur[WIDTH-1:1]};
            OP_LOAD: nxt = ld;
            OP_INV:  nxt = ~cur;
            OP_RR:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_RL:   nxt = {cur[0], cur[WIDTH-1:1]};
            OP_SWAP: nxt = {cur[WIDTH/2-1:0], cur[WIDTH-1:WIDTH/2]};
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg_n.sv
// universal_shift_reg_n: WIDTH-bit universal shift register applying a latched
// opcode for a programmed number of steps, with start/busy/done handshake.
module universal_shift_reg_n
    import ushift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       S,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] I,
    input  logic             sin_lo,
    input  logic             sin_hi,
    output logic [WIDTH-1:0] O,
    output logic             sout_lo,
    output logic             sout_hi,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [2:0]       op;
    logic [WIDTH-1:0] ld, step_val;
    logic [CNT_W-1:0] cnt, cnt_init;

    ushift_step #(.WIDTH(WIDTH)) u_step (
        .op(op),
        .cur(O),
        .ld(ld),
        .sin_lo(sin_lo),
        .sin_hi(sin_hi),
        .nxt(step_val)
    );

    assign cnt_init = (amt == '0) ? '0 : repeats(S) ? amt : CNT_W'(1);
    assign busy     = state != ST_IDLE;
    assign done     = state == ST_DONE;
    assign sout_lo  = O[0];
    assign sout_hi  = O[WIDTH-1];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = !start ? ST_IDLE : (cnt_init == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  state_nxt = (cnt == CNT_W'(1)) ? ST_DONE : ST_RUN;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state <= ST_IDLE;
            O     <= '0;
            cnt   <= '0;
            op    <= OP_HOLD;
            ld    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                op  <= S;
                ld  <= I;
                cnt <= cnt_init;
            end
            if (state == ST_RUN) begin
                O   <= step_val;
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
